// File: rtl/n163_sound_loader.sv
// Burst loader for Namco 163 sound RAM: streams bytes through the $F800 address
// port and the $4800 data port, one bus phase per CPU cycle strobe.
module n163_sound_loader #(
  parameter int LEN_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [6:0]       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic [15:0]      prg_ain,
  output logic             prg_write,
  output logic             prg_read,
  output logic [7:0]       prg_din,
  input  logic [7:0]       prg_dout
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [15:0] A_ADDR_PORT = 16'hF800;
  localparam logic [15:0] A_DATA_PORT = 16'h4800;

  typedef struct packed {
    logic [15:0] ain;
    logic        wr;
    logic        rd;
    logic [7:0]  din;
  } bus_t;

  function automatic bus_t f_bus_idle();
    return '{16'h0000, 1'b0, 1'b0, 8'h00};
  endfunction

  // Bit 7 of the address-port byte turns on the mapper's autoincrement.
  function automatic bus_t f_bus_addr(input logic [6:0] addr);
    return '{A_ADDR_PORT, 1'b1, 1'b0, {1'b1, addr}};
  endfunction

  function automatic bus_t f_bus_wdata(input logic [7:0] d);
    return '{A_DATA_PORT, 1'b1, 1'b0, d};
  endfunction

  function automatic bus_t f_bus_rdata();
    return '{A_DATA_PORT, 1'b0, 1'b1, 8'h00};
  endfunction

  logic [2:0]       r_state;
  logic             r_write;
  logic [6:0]       r_addr;
  logic [LEN_W-1:0] r_rem;
  logic             r_addr_on;
  logic             r_held;
  logic [7:0]       r_byte;
  bus_t             r_bus;
  logic             r_rd_valid;
  logic [7:0]       r_rd_data;
  logic             r_done;

  logic             w_wr_take;
  logic             w_byte_rdy;
  logic [7:0]       w_byte;

  assign cmd_ready  = (r_state == S_IDLE);
  assign wr_ready   = (r_state == S_GAP) && r_write && !r_held;
  assign w_wr_take  = wr_valid && wr_ready;
  // A byte arriving on the very edge that closes GAP still counts as held.
  assign w_byte_rdy = r_held || w_wr_take;
  assign w_byte     = r_held ? r_byte : wr_data;

  assign prg_ain   = r_bus.ain;
  assign prg_write = r_bus.wr;
  assign prg_read  = r_bus.rd;
  assign prg_din   = r_bus.din;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign done      = r_done;

  always_ff @(posedge clk) begin
    if (w_wr_take) r_byte <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_rem      <= '0;
      r_addr_on  <= 1'b0;
      r_held     <= 1'b0;
      r_bus      <= f_bus_idle();
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'h00;
      r_done     <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      if (w_wr_take) r_held <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_write   <= cmd_write;
            r_addr    <= cmd_addr;
            r_rem     <= cmd_len;
            r_addr_on <= 1'b0;
            r_state   <= S_ADDR;
          end
        end
        // The address phase opens on the first strobe after the command is taken.
        S_ADDR: begin
          if (ce) begin
            if (!r_addr_on) begin
              r_bus     <= f_bus_addr(r_addr);
              r_addr_on <= 1'b1;
            end else begin
              r_bus   <= f_bus_idle();
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (ce && (!r_write || w_byte_rdy)) begin
            r_bus   <= r_write ? f_bus_wdata(w_byte) : f_bus_rdata();
            r_held  <= 1'b0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (ce) begin
            r_bus <= f_bus_idle();
            if (!r_write) begin
              r_rd_valid <= 1'b1;
              r_rd_data  <= prg_dout;
            end
            if (r_rem == '0) begin
              r_state <= S_DONE;
            end else begin
              r_rem   <= r_rem - LEN_W'(1);
              r_state <= S_GAP;
            end
          end
        end
        S_DONE: begin
          if (ce) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n163_sound_loader.sv
// Bench for n163_sound_loader: mapper model on the bus, expected phase lists and
// RAM contents derived from the burst parameters.
module tb_n163_sound_loader;
  logic        clk = 1'b0;
  logic        reset, ce, cmd_valid, cmd_ready, cmd_write;
  logic [6:0]  cmd_addr, cmd_len;
  logic        wr_valid, wr_ready, rd_valid, done, prg_write, prg_read;
  logic [7:0]  wr_data, rd_data, prg_din, prg_dout;
  logic [15:0] prg_ain;

  always #5 clk = ~clk;

  n163_sound_loader #(.LEN_W(7)) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done),
    .prg_ain(prg_ain), .prg_write(prg_write), .prg_read(prg_read),
    .prg_din(prg_din), .prg_dout(prg_dout)
  );

  typedef struct packed {
    logic [15:0] ain;
    logic        w;
    logic        r;
    logic [7:0]  din;
  } ph_t;

  localparam ph_t IDLE_PH = '{16'h0000, 1'b0, 1'b0, 8'h00};

  int checks = 0;
  int failures = 0;
  int viol = 0;
  int bad_wr_ready = 0;
  ph_t rec[$];
  ph_t expq[$];
  logic [7:0] rdq[$];
  logic [7:0] rdexp[$];
  logic [7:0] wbytes[$];
  logic [7:0] shadow [128];

  // Mapper: address port latches pointer/autoincrement, data port accesses RAM
  logic [7:0] map_ram [128];
  logic [6:0] map_addr;
  logic       map_inc;
  assign prg_dout = map_ram[map_addr];

  always @(posedge clk) begin
    if (ce) begin
      if (prg_write && prg_ain == 16'hF800) begin
        map_addr <= prg_din[6:0];
        map_inc  <= prg_din[7];
      end else if (prg_ain == 16'h4800 && (prg_write || prg_read)) begin
        if (prg_write) map_ram[map_addr] <= prg_din;
        if (map_inc) map_addr <= 7'(map_addr + 7'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (prg_write && prg_read) viol = viol + 1;
    if (prg_ain[15:12] == 4'h5) viol = viol + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic ph_t mk(input logic [15:0] a, input logic w, input logic r, input logic [7:0] d);
    ph_t p;
    p = '{a, w, r, d};
    return p;
  endfunction

  task automatic ram_check(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < 128; i++) if (map_ram[i] !== shadow[i]) bad++;
    chk(nm, 32'(bad), 32'd0);
  endtask

  // One command from issue to done (or to a planted reset after rst_after data phases).
  task automatic run_burst(input bit wr, input logic [6:0] addr, input int len, input int period,
                           input int stall_idx, input int stall_n, input int rst_after);
    int bi, withheld, n_data, budget, dn;
    bit prev_v, prev_r, fin, aborted, ce_now, wv;
    ph_t a, e;
    bi = 0; withheld = 0; n_data = 0; prev_v = 0; prev_r = 0; fin = 0; aborted = 0;
    expq.delete(); rec.delete(); rdq.delete(); rdexp.delete();
    if (wr) while (wbytes.size() < len + 1) wbytes.push_back(8'($urandom));
    expq.push_back(IDLE_PH);
    expq.push_back(mk(16'hF800, 1'b1, 1'b0, {1'b1, addr}));
    for (int i = 0; i <= len; i++) begin
      for (int k = 0; k < 1 + ((i == stall_idx) ? stall_n : 0); k++) expq.push_back(IDLE_PH);
      if (wr) expq.push_back(mk(16'h4800, 1'b1, 1'b0, wbytes[i]));
      else begin
        expq.push_back(mk(16'h4800, 1'b0, 1'b1, 8'h00));
        rdexp.push_back(shadow[7'(addr + 7'(i))]);
      end
    end
    expq.push_back(IDLE_PH);
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = 7'(len);
    budget = (len + 1) * (2 + stall_n) * period + 6 * period + 20;
    for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
      @(negedge clk);
      if (prev_v && prev_r) bi++;
      if (rd_valid) rdq.push_back(rd_data);
      if (done) begin
        fin = 1;
      end else if (rst_after > 0 && n_data >= rst_after && prg_ain == 16'h4800) begin
        reset = 1'b1; ce = 1'b0; cmd_valid = 1'b0; wr_valid = 1'b0;
        #1;
        chk("rst_ain", 32'(prg_ain), 32'd0);
        chk("rst_write", 32'(prg_write), 32'd0);
        chk("rst_read", 32'(prg_read), 32'd0);
        chk("rst_din", 32'(prg_din), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        dn = 0;
        repeat (3) begin @(negedge clk); if (done) dn++; end
        reset = 1'b0;
        repeat (3) begin @(negedge clk); if (done) dn++; end
        chk("rst_no_done", 32'(dn), 32'd0);
        fin = 1; aborted = 1;
      end else begin
        if (!wr && wr_ready) bad_wr_ready++;
        cmd_valid = 1'($urandom_range(0, 1)); cmd_write = 1'($urandom);
        cmd_addr = 7'($urandom); cmd_len = 7'($urandom);
        ce_now = (cyc % period == 0);
        if (ce_now) begin
          rec.push_back(mk(prg_ain, prg_write, prg_read, prg_din));
          if (prg_ain == 16'h4800) n_data++;
        end
        ce = ce_now;
        if (wr) begin
          wv = 0;
          if (wr_ready && bi <= len) begin
            if (bi == stall_idx && withheld < stall_n) begin
              if (ce_now) withheld++;
            end else wv = 1;
          end
          wr_valid = wv;
          wr_data = wv ? wbytes[bi] : 8'($urandom);
        end else begin
          wr_valid = 1'($urandom_range(0, 1));
          wr_data = 8'($urandom);
        end
        prev_v = wr_valid; prev_r = wr_ready;
      end
    end
    ce = 1'b0; cmd_valid = 1'b0; wr_valid = 1'b0;
    chk("burst_finished", 32'(fin), 32'd1);
    if (aborted) begin
      for (int i = 0; i < n_data; i++) shadow[7'(addr + 7'(i))] = wbytes[i];
    end else begin
      chk("phase_count", 32'(rec.size()), 32'(expq.size()));
      for (int i = 0; i < rec.size() && i < expq.size(); i++) begin
        a = rec[i]; e = expq[i];
        if (e.r) begin a.din = 8'h00; e.din = 8'h00; end
        chk($sformatf("phase%0d", i), 32'(a), 32'(e));
      end
      if (wr) begin
        for (int i = 0; i <= len; i++) shadow[7'(addr + 7'(i))] = wbytes[i];
      end else begin
        chk("rd_count", 32'(rdq.size()), 32'(rdexp.size()));
        for (int i = 0; i < rdq.size() && i < rdexp.size(); i++)
          chk($sformatf("rd_byte%0d", i), 32'(rdq[i]), 32'(rdexp[i]));
      end
    end
    ram_check("ram_match");
    wbytes.delete();
  endtask

  initial begin
    int adj, len, sidx, sn;
    logic [6:0] ra;
    bit rw;
    reset = 1'b1; ce = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_ain", 32'(prg_ain), 32'd0);
    chk("reset_write", 32'(prg_write), 32'd0);
    chk("reset_read", 32'(prg_read), 32'd0);
    chk("reset_din", 32'(prg_din), 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_wr_ready", 32'(wr_ready), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    reset = 1'b0;

    // Fill the whole RAM so every later read has a known value
    run_burst(1'b1, 7'h00, 127, $urandom_range(2, 5), -1, 0, 0);

    wbytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_burst(1'b1, 7'h40, 3, 12, -1, 0, 0);
    chk("w40_phases", 32'(rec.size() - 1), 32'd10);
    chk("w40_addr_phase", 32'(rec[1]), 32'(mk(16'hF800, 1'b1, 1'b0, 8'hC0)));
    chk("w40_first_data", 32'(rec[3]), 32'(mk(16'h4800, 1'b1, 1'b0, 8'h11)));
    chk("w40_last_data", 32'(rec[9]), 32'(mk(16'h4800, 1'b1, 1'b0, 8'h44)));
    chk("w40_gap_idle", 32'(rec[4]), 32'd0);
    chk("w40_ram40", 32'(map_ram[7'h40]), 32'h11);
    chk("w40_ram43", 32'(map_ram[7'h43]), 32'h44);

    run_burst(1'b0, 7'h40, 3, 12, -1, 0, 0);
    chk("r40_pulses", 32'(rdq.size()), 32'd4);
    chk("r40_b0", 32'(rdq[0]), 32'h11);
    chk("r40_b1", 32'(rdq[1]), 32'h22);
    chk("r40_b3", 32'(rdq[3]), 32'h44);
    adj = 0;
    foreach (rec[i]) if (rec[i].ain == 16'h4800 && rec[i].w) adj++;
    chk("r40_no_write_in_data", 32'(adj), 32'd0);

    wbytes = '{8'h31, 8'h32, 8'h33, 8'h34};
    run_burst(1'b1, 7'h10, 3, 6, 2, 3, 0);
    chk("stall_phases", 32'(rec.size()), 32'd14);
    chk("stall_d2_pos", 32'(rec[10]), 32'(mk(16'h4800, 1'b1, 1'b0, 8'h33)));
    chk("stall_idle9", 32'(rec[9]), 32'd0);
    chk("stall_ram12", 32'(map_ram[7'h12]), 32'h33);

    wbytes = '{8'hA5, 8'h5A};
    run_burst(1'b1, 7'h7F, 1, 4, -1, 0, 0);
    chk("wrap_ram7f", 32'(map_ram[7'h7F]), 32'hA5);
    chk("wrap_ram00", 32'(map_ram[7'h00]), 32'h5A);

    for (int t = 0; t < 8; t++) begin
      rw = 1'($urandom);
      ra = 7'($urandom);
      len = $urandom_range(0, 15);
      sidx = rw ? $urandom_range(0, len) : -1;
      sn = rw ? $urandom_range(0, 3) : 0;
      run_burst(rw, ra, len, $urandom_range(2, 12), sidx, sn, 0);
    end

    ra = 7'($urandom);
    run_burst(1'b1, ra, 127, 3, -1, 0, $urandom_range(5, 60));
    run_burst(1'b0, ra, 0, 4, -1, 0, 0);
    chk("after_rst_pulses", 32'(rdq.size()), 32'd1);
    chk("after_rst_addr_phase", 32'(rec[1].ain), 32'hF800);

    run_burst(1'b0, 7'($urandom), 127, 2, -1, 0, 0);
    chk("r128_pulses", 32'(rdq.size()), 32'd128);
    chk("r128_phases", 32'(rec.size() - 1), 32'd258);
    adj = 0;
    for (int i = 1; i < rec.size(); i++)
      if (rec[i].ain == 16'h4800 && rec[i-1].ain == 16'h4800) adj++;
    chk("r128_no_adjacent_data", 32'(adj), 32'd0);

    chk("bus_invariants", 32'(viol), 32'd0);
    chk("wr_ready_in_read", 32'(bad_wr_ready), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/n163_sound_loader.md
N163_SOUND_LOADER -- requirements
Module: n163_sound_loader

Interface
REQ-001 SHALL have parameter LEN_W, default 7, giving the burst length width; a burst is up to 2^LEN_W = 128 bytes.
REQ-002 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port ce  in  1  CPU-cycle strobe (M2), one clk wide, at least 2 clk apart.
REQ-005 SHALL have port cmd_valid  in  1  command offered.
REQ-006 SHALL have port cmd_ready  out  1  high only in IDLE.
REQ-007 SHALL have port cmd_write  in  1  1 = burst write to sound RAM, 0 = burst read.
REQ-008 SHALL have port cmd_addr  in  7  sound-RAM start address.
REQ-009 SHALL have port cmd_len  in  LEN_W  byte count minus 1.
REQ-010 SHALL have port wr_valid / wr_ready  in / out  1 / 1  write-data stream handshake.
REQ-011 SHALL have port wr_data  in  8  write byte.
REQ-012 SHALL have port rd_valid  out  1  one-clk pulse with each read byte.
REQ-013 SHALL have port rd_data  out  8  read byte.
REQ-014 SHALL have port done  out  1  one-clk pulse at burst end.
REQ-015 SHALL have port prg_ain  out  16  CPU address to mapper.
REQ-016 SHALL have port prg_write / prg_read  out  1 / 1  CPU write / read strobes.
REQ-017 SHALL have port prg_din  out  8  CPU data to mapper.
REQ-018 SHALL have port prg_dout  in  8  data from mapper.

Function
REQ-019 SHALL drive bus outputs from registers that update only on clk edges with ce=1; each bus phase lasts from one ce edge to the next, and the mapper samples it at the closing ce edge.
REQ-020 SHALL implement states IDLE, ADDR, GAP, DATA, DONE.
REQ-021 Idle bus phase SHALL be prg_ain=$0000, prg_write=0, prg_read=0, prg_din=$00.
REQ-022 IDLE: on cmd_valid&&cmd_ready, SHALL latch write/addr/len, set remaining=cmd_len, and go to ADDR.
REQ-023 ADDR phase SHALL drive prg_ain=$F800, prg_write=1, prg_din={1'b1,addr} (autoincrement on), then go to GAP.
REQ-024 DATA write phase SHALL drive prg_ain=$4800, prg_write=1, prg_din=captured byte.
REQ-025 DATA read phase SHALL drive prg_ain=$4800, prg_read=1, prg_write=0.
REQ-026 After every DATA phase, SHALL insert exactly one idle GAP phase before the next DATA phase, so the mapper's deferred address increment lands first; back-to-back $4800 phases are forbidden.
REQ-027 Write burst: wr_ready SHALL be high in GAP while no byte is held.
- The byte SHALL be captured on wr_valid&&wr_ready.
- If no byte is held when GAP closes, GAP SHALL extend by whole phases (bus idle) until one is.
REQ-028 Read burst: SHALL sample prg_dout at the ce edge closing each DATA phase and pulse rd_valid with rd_data on that clk.
REQ-029 remaining SHALL decrement at each DATA close; DATA with remaining=0 SHALL go to DONE.
REQ-030 DONE SHALL present one idle phase, pulse done at its closing ce edge, and return to IDLE.
REQ-031 cmd_len=0 SHALL transfer exactly 1 byte; cmd_len=127 SHALL transfer 128 bytes.
REQ-032 Address wrap in the mapper ($7F to $00) SHALL need no special handling; no internal address is kept.
REQ-033 SHALL never drive prg_write and prg_read high together, and SHALL never present a $5000-$5FFF address.
REQ-034 cmd_valid outside IDLE SHALL be ignored.
REQ-035 wr_valid outside write GAP SHALL be ignored.

Reset
REQ-036 While reset is high, SHALL hold state=IDLE, the idle bus phase (REQ-021), cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=$00, done=0, remaining=0.
REQ-037 Reset asserted mid-burst SHALL abort immediately with no done pulse; the next command after release SHALL start with ADDR.

Verification
REQ-038 Bench SHALL cover: write addr=$40, len=3, bytes $11,$22,$33,$44, ce every 12 clk -> bus sequence F800/$C0, idle, 4800/$11, idle, 4800/$22, idle, 4800/$33, idle, 4800/$44, idle; done after 10 phases; mapper RAM[$40..$43] correct.
REQ-039 Bench SHALL cover: read back the same range with a mapper model -> rd_data $11,$22,$33,$44 in order, 4 rd_valid pulses, no prg_write during DATA.
REQ-040 Bench SHALL cover: write with wr_valid withheld for 3 phases before byte 2 -> exactly 3 extra idle phases, data still correct.
REQ-041 Bench SHALL cover: addr=$7F, len=1 write -> bytes land at $7F then $00.
REQ-042 Bench SHALL cover: reset pulsed during DATA of a 128-byte write -> outputs idle within the same clk, no done; a following 1-byte read completes normally.
REQ-043 Bench SHALL cover: ce at minimum 2-clk spacing over a 128-byte read -> 128 rd_valid pulses, 257 phases plus DONE, no $4800 phases adjacent.
